// File: rtl/axis_step_sequencer_pkg.sv
// Shared constants and types for the axis step sequencer.
package axis_step_sequencer_pkg;

  // Register offsets from BASE_ADDR.
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RATE_L = 2'd1;
  localparam logic [1:0] REG_RATE_H = 2'd2;
  localparam logic [1:0] REG_STEPS  = 2'd3;

  // CTRL bit indices.
  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_STOP    = 1;
  localparam int unsigned CTRL_BOUNCE  = 2;
  localparam int unsigned CTRL_DIR0    = 3;
  localparam int unsigned CTRL_IRQ_ACK = 7;

  // Step command encoding on oper.
  localparam logic [1:0] OP_INC  = 2'b10;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_HOLD = 2'b00;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFinish = 2'd2
  } state_e;

endpackage

// File: rtl/axis_step_sequencer_rate_divider.sv
// Step-rate divider: counts 0..term and pulses tick at term; term latches RATE (min 1) on reload.
module step_rate_divider #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] term_q;
  logic [DIV_W-1:0] rate_eff;

  assign rate_eff = (rate == '0) ? DIV_W'(1) : rate;
  assign tick     = enable && (cnt_q == term_q);

  // The terminal value is only sampled on clear or tick so RATE writes apply at the next reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      term_q <= '0;
    end else if (clear) begin
      cnt_q  <= '0;
      term_q <= rate_eff;
    end else if (enable) begin
      if (tick) begin
        cnt_q  <= '0;
        term_q <= rate_eff;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/axis_step_sequencer.sv
// Single-axis step sequencer configured over the PicoBlaze port bus.
// Optional interrupt latch enabled by defining STEP_SEQ_IRQ_EN.
module axis_step_sequencer
  import axis_step_sequencer_pkg::*;
#(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned STEP_W    = 8,
  parameter logic [7:0]  BASE_ADDR = 8'h10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic [7:0] out_port,
  input  logic       write_strobe,
  input  logic       x_min,
  input  logic       x_max,
  output logic [1:0] oper,
  output logic       busy,
  output logic       done,
  output logic [7:0] status,
  output logic       irq
);

  state_e state_q, state_d;

  logic [7:0]        offset;
  logic              hit;
  logic              wr_ctrl;
  logic              start_w;
  logic              stop_w;

  logic [DIV_W-1:0]  rate_q;
  logic [STEP_W-1:0] steps_q;
  logic              bounce_q;

  logic              dir_q, dir_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              limited_q, limited_d;
  logic              hmax_q, hmax_d;
  logic              hmin_q, hmin_d;

  logic              div_clear;
  logic              div_tick;
  logic              limit_hit;
  logic              step_dir;

  assign offset  = port_id - BASE_ADDR;
  assign hit     = write_strobe && (offset[7:2] == 6'd0);
  assign wr_ctrl = hit && (offset[1:0] == REG_CTRL);
  assign start_w = wr_ctrl && out_port[CTRL_START];
  assign stop_w  = wr_ctrl && out_port[CTRL_STOP];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rate_q   <= '0;
      steps_q  <= '0;
      bounce_q <= 1'b0;
    end else if (hit) begin
      unique case (offset[1:0])
        REG_CTRL:   bounce_q <= out_port[CTRL_BOUNCE];
        REG_RATE_L: rate_q[7:0] <= out_port;
        REG_RATE_H: rate_q[DIV_W-1:8] <= out_port[DIV_W-9:0];
        REG_STEPS:  steps_q <= out_port[STEP_W-1:0];
        default:    ;
      endcase
    end
  end

  // Kept outside the FSM process so the divider's tick never feeds back into its own clear.
  assign div_clear = (state_q != StRun) || start_w || stop_w;
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StFinish);

  step_rate_divider #(
    .DIV_W(DIV_W)
  ) u_divider (
    .clk    (clk),
    .reset  (reset),
    .clear  (div_clear),
    .enable (busy),
    .rate   (rate_q),
    .tick   (div_tick)
  );

  assign limit_hit = dir_q ? x_max : x_min;
  assign step_dir  = limit_hit ? ~dir_q : dir_q;

  always_comb begin
    state_d   = state_q;
    oper      = OP_HOLD;
    dir_d     = dir_q;
    rem_d     = rem_q;
    limited_d = limited_q;
    hmax_d    = hmax_q;
    hmin_d    = hmin_q;
    unique case (state_q)
      StIdle: begin
        if (start_w && !stop_w) begin
          state_d   = StRun;
          dir_d     = out_port[CTRL_DIR0];
          rem_d     = steps_q;
          limited_d = (steps_q != '0);
          hmax_d    = 1'b0;
          hmin_d    = 1'b0;
        end
      end
      StRun: begin
        if (stop_w) begin
          state_d = StIdle;
        end else if (start_w) begin
          dir_d     = out_port[CTRL_DIR0];
          rem_d     = steps_q;
          limited_d = (steps_q != '0);
          hmax_d    = 1'b0;
          hmin_d    = 1'b0;
        end else if (div_tick) begin
          if (limit_hit && !bounce_q) begin
            state_d = StFinish;
            if (dir_q) begin
              hmax_d = 1'b1;
            end else begin
              hmin_d = 1'b1;
            end
          end else begin
            dir_d = step_dir;
            oper  = step_dir ? OP_INC : OP_DEC;
            if (limited_q && (rem_q != '0)) begin
              rem_d = rem_q - STEP_W'(1);
              if (rem_q == STEP_W'(1)) begin
                state_d = StFinish;
              end
            end
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      dir_q     <= 1'b0;
      rem_q     <= '0;
      limited_q <= 1'b0;
      hmax_q    <= 1'b0;
      hmin_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      rem_q     <= rem_d;
      limited_q <= limited_d;
      hmax_q    <= hmax_d;
      hmin_q    <= hmin_d;
    end
  end

`ifdef STEP_SEQ_IRQ_EN
  logic irq_q;
  logic ack_w;

  assign ack_w = wr_ctrl && out_port[CTRL_IRQ_ACK];

  // Set has priority so a done pulse coinciding with an ack is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else if (done) begin
      irq_q <= 1'b1;
    end else if (ack_w) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign status = {irq, 3'b000, hmax_q, hmin_q, dir_q, busy};

endmodule

// File: tb/tb_axis_step_sequencer.sv
// Directed, table-driven bench for axis_step_sequencer.
module tb_axis_step_sequencer;

  localparam logic [7:0] B    = 8'h10;
  localparam logic [7:0] CTRL = B;
  localparam logic [7:0] RL   = B + 8'd1;
  localparam logic [7:0] RH   = B + 8'd2;
  localparam logic [7:0] STP  = B + 8'd3;
`ifdef STEP_SEQ_IRQ_EN
  localparam logic [7:0] IRQF = 8'h80;
`else
  localparam logic [7:0] IRQF = 8'h00;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       x_min;
  logic       x_max;
  logic [1:0] oper;
  logic       busy;
  logic       done;
  logic [7:0] status;
  logic       irq;

  int n_chk;
  int n_fail;

  typedef struct {
    logic [7:0] pid;
    logic [7:0] data;
    logic       wr;
    logic       xmin;
    logic       xmax;
    logic [1:0] oper;
    logic       busy;
    logic       done;
    logic       st_chk;
    logic [7:0] status;
  } vec_t;

  vec_t run1[23];

  axis_step_sequencer #(
    .DIV_W     (16),
    .STEP_W    (8),
    .BASE_ADDR (B)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .port_id      (port_id),
    .out_port     (out_port),
    .write_strobe (write_strobe),
    .x_min        (x_min),
    .x_max        (x_max),
    .oper         (oper),
    .busy         (busy),
    .done         (done),
    .status       (status),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] pid, input logic [7:0] data, input logic wr,
                              input logic xmin, input logic xmax, input logic [1:0] op,
                              input logic b, input logic d, input logic sc,
                              input logic [7:0] st);
    vec_t v;
    v.pid = pid; v.data = data; v.wr = wr; v.xmin = xmin; v.xmax = xmax;
    v.oper = op; v.busy = b; v.done = d; v.st_chk = sc; v.status = st;
    return v;
  endfunction

  // Idle-bus cycle with expected outputs.
  function automatic vec_t cy(input logic xmin, input logic xmax, input logic [1:0] op,
                              input logic b, input logic d, input logic sc,
                              input logic [7:0] st);
    return mk(8'h00, 8'h00, 1'b0, xmin, xmax, op, b, d, sc, st);
  endfunction

  // Called just after a posedge; inputs hold for one cycle, outputs sampled at negedge.
  task automatic apply(input vec_t v, input string nm);
    port_id      = v.pid;
    out_port     = v.data;
    write_strobe = v.wr;
    x_min        = v.xmin;
    x_max        = v.xmax;
    @(negedge clk);
    chk({nm, " oper"}, {6'd0, oper}, {6'd0, v.oper});
    chk({nm, " busy"}, {7'd0, busy}, {7'd0, v.busy});
    chk({nm, " done"}, {7'd0, done}, {7'd0, v.done});
    if (v.st_chk) begin
      chk({nm, " status"}, status, v.status);
      chk({nm, " irq"}, {7'd0, irq}, {7'd0, v.status[7]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] pid, input logic [7:0] data, input string nm);
    apply(mk(pid, data, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00), nm);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // RATE=3, STEPS=5, up: steps every 4 cycles from cycle 4, done at 21, idle at 22.
    for (int c = 0; c < 23; c++) begin
      run1[c] = cy(1'b0, 1'b0, 2'b00, (c >= 1 && c <= 20), (c == 21), 1'b0, 8'h00);
      if (c >= 4 && c <= 20 && (c % 4) == 0) run1[c].oper = 2'b10;
    end
    run1[0].pid  = CTRL;
    run1[0].data = 8'h09;
    run1[0].wr   = 1'b1;
    run1[1].st_chk  = 1'b1;
    run1[1].status  = 8'h03;
    run1[22].st_chk = 1'b1;
    run1[22].status = 8'h02;

    reset        = 1'b1;
    port_id      = 8'h00;
    out_port     = 8'h00;
    write_strobe = 1'b0;
    x_min        = 1'b0;
    x_max        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset oper", {6'd0, oper}, 8'h00);
    chk("reset busy", {7'd0, busy}, 8'h00);
    chk("reset done", {7'd0, done}, 8'h00);
    chk("reset status", status, 8'h00);
    chk("reset irq", {7'd0, irq}, 8'h00);
    reset = 1'b0;
    @(posedge clk);
    #1;

    wr(RL, 8'd3, "w rate_l");
    wr(RH, 8'd0, "w rate_h");
    wr(STP, 8'd5, "w steps");
    for (int c = 0; c < 23; c++) apply(run1[c], $sformatf("run1[%0d]", c));

    // Bounce: RATE=1, unlimited, up; x_max reverses at tick 4, x_min reverses at tick 8,
    // then STOP lands on tick 10.
    wr(RL, 8'd1, "w rate_l b");
    wr(STP, 8'd0, "w steps b");
    apply(mk(CTRL, 8'h0D, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00), "bnc0");
    apply(cy(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h03), "bnc1");
    apply(cy(1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00), "bnc2");
    apply(cy(1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00), "bnc3");
    apply(cy(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00), "bnc4");
    apply(cy(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h01), "bnc5");
    apply(cy(1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00), "bnc6");
    apply(cy(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00), "bnc7");
    apply(cy(1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00), "bnc8");
    apply(cy(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h03), "bnc9");
    apply(mk(CTRL, 8'h02, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00), "stop_tick");
    apply(cy(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h02), "stop1");
    apply(cy(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00), "stop2");

    // Halt at min with both flags high (dir down uses x_min); ack coincides with done.
    apply(mk(CTRL, 8'h01, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00), "halt0");
    apply(cy(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 8'h01), "halt1");
    apply(cy(1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00), "halt2");
    apply(mk(CTRL, 8'h80, 1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h04), "halt3");
    apply(cy(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h04 | IRQF), "halt4");
    apply(mk(CTRL, 8'h80, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h04 | IRQF), "ack0");
    apply(cy(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h04), "ack1");

    // Asynchronous reset in the middle of a step cycle.
    apply(mk(CTRL, 8'h09, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00), "rst0");
    apply(cy(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h03), "rst1");
    @(negedge clk);
    chk("rst2 oper", {6'd0, oper}, 8'h02);
    #2;
    reset = 1'b1;
    #1;
    chk("async oper", {6'd0, oper}, 8'h00);
    chk("async busy", {7'd0, busy}, 8'h00);
    chk("async status", status, 8'h00);
    chk("async irq", {7'd0, irq}, 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First run after reset: RATE back to 0, treated as 1 (period 2).
    apply(mk(CTRL, 8'h09, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00), "post0");
    apply(cy(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 8'h03), "post1");
    apply(cy(1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00), "post2");
    apply(cy(1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00), "post3");
    apply(cy(1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00), "post4");
    apply(mk(CTRL, 8'h02, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00), "post5");
    apply(cy(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 8'h02), "post6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
